// File: rtl/dmem_arbiter_if.sv
// Bundle of signals between the data-memory arbiter, its two requesters
// (core and debug/loader) and the synchronous-read memory behind it.
// The arbiter connects through the slave modport; the master modport is the
// view of the requesters and memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Core requester
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [BE_W-1:0]   c_be;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    // Debug / loader requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_be,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_be,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core + debug/loader) in front of a
// synchronous-read memory. Each access runs IDLE -> ACCESS -> RESP, so one
// access completes every three cycles.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; when
// undefined the core always wins a tie and no last-winner state is kept.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    port_e             winner_q;

    logic gnt_core, gnt_dbg;
    logic prefer_core;
    logic in_access, in_resp;

`ifdef DMEM_ARB_RR_EN
    port_e last_winner_q;

    // On a tie the core is preferred only if debug was granted last.
    assign prefer_core = (last_winner_q == PORT_DBG);

    // Remember who won the most recent grant; reset favours the core next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= PORT_DBG;
        end else if (gnt_core) begin
            last_winner_q <= PORT_CORE;
        end else if (gnt_dbg) begin
            last_winner_q <= PORT_DBG;
        end
    end
`else
    assign prefer_core = 1'b1;
`endif

    // Next state and one-hot grant; grants only exist in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        gnt_core = 1'b0;
        gnt_dbg  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_core = bus.c_req && (!bus.d_req || prefer_core);
                gnt_dbg  = bus.d_req && !gnt_core;
                if (gnt_core || gnt_dbg) begin
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and capture of the winner's payload at grant time.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the captured payload is reset too, so the memory bus shows
            // zeros rather than stale data after reset.
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            winner_q <= PORT_CORE;
        end else begin
            state_q <= state_d;
            if (gnt_core) begin
                we_q     <= bus.c_we;
                addr_q   <= bus.c_addr;
                wdata_q  <= bus.c_wdata;
                be_q     <= bus.c_be;
                winner_q <= PORT_CORE;
            end else if (gnt_dbg) begin
                we_q     <= bus.d_we;
                addr_q   <= bus.d_addr;
                wdata_q  <= bus.d_wdata;
                be_q     <= bus.d_be;
                winner_q <= PORT_DBG;
            end
        end
    end

    // Outputs are masked while rst is high so an aborted access never leaks
    // a memory strobe or a response during the reset cycle.
    assign in_access = (state_q == ACCESS) && !rst;
    assign in_resp   = (state_q == RESP) && !rst;

    assign bus.c_gnt = gnt_core && !rst;
    assign bus.d_gnt = gnt_dbg && !rst;

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && we_q;
    assign bus.mem_addr  = in_access ? addr_q  : '0;
    assign bus.mem_wdata = in_access ? wdata_q : '0;
    assign bus.mem_be    = in_access ? be_q    : '0;

    assign bus.c_rvalid = in_resp && (winner_q == PORT_CORE);
    assign bus.d_rvalid = in_resp && (winner_q == PORT_DBG);
    assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a byte-enabled synchronous-read memory
// model sits behind the arbiter; expected values are hand-computed.
module tb_dmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after mem_en.
    logic [31:0] mem [logic [31:0]];
    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.mem_en) begin
            w = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                mem[bus.mem_addr] = w;
            end else begin
                bus.mem_rdata <= w;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [3:0] exp_core;

    initial begin
        total = 0;
        bad   = 0;
`ifdef DMEM_ARB_RR_EN
        exp_core = 4'b0101;
`else
        exp_core = 4'b1111;
`endif
        mem[32'h10] = 32'hDEADBEEF;
        bus.mem_rdata = '0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_be = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

        // ---- reset: outputs quiet even with a request present
        rst = 1;
        tick();
        tick();
        bus.c_req = 1;
        settle();
        chk("rst_c_gnt",  bus.c_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_rvalid", {bus.c_rvalid, bus.d_rvalid}, 0);
        chk("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_be}, 0);
        bus.c_req = 0;
        rst = 0;
        tick();

        // ---- core read of 0x10
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
        settle();
        chk("rd_c_gnt", {bus.c_gnt, bus.d_gnt, bus.mem_en}, 3'b100);
        tick();
        bus.c_req = 0;
        settle();
        chk("rd_access", {bus.mem_en, bus.mem_we, bus.c_gnt}, 3'b100);
        chk("rd_addr", bus.mem_addr, 32'h10);
        chk("rd_no_rvalid_early", {bus.c_rvalid, bus.d_rvalid}, 0);
        tick();
        chk("rd_rvalid", {bus.c_rvalid, bus.d_rvalid, bus.mem_en}, 3'b100);
        chk("rd_rdata", bus.c_rdata, 32'hDEADBEEF);
        chk("rd_d_rdata_zero", bus.d_rdata, 0);
        tick();
        chk("rd_rvalid_drop", {bus.c_rvalid, bus.d_rvalid}, 0);
        chk("rd_rdata_zero", bus.c_rdata, 0);

        // ---- debug write of 0x12345678 to 0x20
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678; bus.d_be = 4'hF;
        settle();
        chk("wr_gnt", {bus.c_gnt, bus.d_gnt}, 2'b01);
        tick();
        bus.d_req = 0;
        settle();
        chk("wr_access", {bus.mem_en, bus.mem_we}, 2'b11);
        chk("wr_addr", bus.mem_addr, 32'h20);
        chk("wr_data", bus.mem_wdata, 32'h12345678);
        chk("wr_be", bus.mem_be, 4'hF);
        tick();
        chk("wr_ack", {bus.d_rvalid, bus.c_rvalid, bus.mem_en, bus.mem_we}, 4'b1000);
        tick();
        chk("wr_ack_drop", bus.d_rvalid, 0);

        // ---- core write with zero byte enables; payload changed after grant
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h20; bus.c_wdata = 32'hFFFFFFFF; bus.c_be = 4'h0;
        settle();
        chk("be0_gnt", bus.c_gnt, 1);
        tick();
        bus.c_req = 0; bus.c_addr = 32'h99; bus.c_wdata = 32'h0; bus.c_be = 4'hF; bus.c_we = 0;
        settle();
        chk("be0_access", {bus.mem_en, bus.mem_we, bus.mem_be}, 6'b110000);
        chk("be0_addr_latched", bus.mem_addr, 32'h20);
        chk("be0_wdata_latched", bus.mem_wdata, 32'hFFFFFFFF);
        tick();
        chk("be0_ack", bus.c_rvalid, 1);
        tick();

        // ---- core read while debug arrives mid-access; debug reads back 0x20
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
        settle();
        chk("late_c_gnt", bus.c_gnt, 1);
        tick();
        bus.c_req = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20; bus.d_be = 4'hF;
        settle();
        chk("late_no_gnt_access", {bus.c_gnt, bus.d_gnt}, 0);
        tick();
        chk("late_no_gnt_resp", {bus.c_gnt, bus.d_gnt}, 0);
        chk("late_c_rdata", bus.c_rdata, 32'hDEADBEEF);
        tick();
        chk("late_d_gnt_idle", {bus.c_gnt, bus.d_gnt}, 2'b01);
        tick();
        bus.d_req = 0;
        settle();
        chk("late_d_addr", bus.mem_addr, 32'h20);
        tick();
        chk("late_d_rvalid", {bus.d_rvalid, bus.c_rvalid}, 2'b10);
        chk("be0_mem_unchanged", bus.d_rdata, 32'h12345678);
        tick();

        // ---- tie held for four accesses straight after reset
        rst = 1;
        tick();
        rst = 0;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h10; bus.c_be = 4'hF;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h20; bus.d_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("tie%0d_gnt", k), {bus.c_gnt, bus.d_gnt}, {exp_core[k], ~exp_core[k]});
            tick();
            chk($sformatf("tie%0d_access_nognt", k), {bus.c_gnt, bus.d_gnt}, 0);
            chk($sformatf("tie%0d_addr", k), bus.mem_addr, exp_core[k] ? 32'h10 : 32'h20);
            tick();
            chk($sformatf("tie%0d_rvalid", k), {bus.c_rvalid, bus.d_rvalid}, {exp_core[k], ~exp_core[k]});
            tick();
        end
        bus.c_req = 0;
        settle();

        // ---- lone debug request granted whatever won last
        chk("lone_d_gnt", {bus.c_gnt, bus.d_gnt}, 2'b01);
        tick();
        bus.d_req = 0;
        tick();
        chk("lone_d_rvalid", bus.d_rvalid, 1);
        tick();

        // ---- reset during ACCESS of a core read aborts it
        bus.c_req = 1; bus.c_addr = 32'h10; bus.c_we = 0;
        settle();
        chk("abort_c_gnt", bus.c_gnt, 1);
        tick();
        bus.c_req = 0;
        rst = 1;
        settle();
        chk("abort_outputs", {bus.mem_en, bus.mem_we, bus.c_rvalid, bus.d_rvalid}, 0);
        chk("abort_mem_addr", bus.mem_addr, 0);
        tick();
        rst = 0;
        settle();
        chk("abort_no_rvalid0", {bus.c_rvalid, bus.mem_en}, 0);
        tick();
        chk("abort_no_rvalid1", {bus.c_rvalid, bus.mem_en}, 0);
        bus.c_req = 1; bus.d_req = 1; bus.d_addr = 32'h20;
        settle();
        chk("abort_tie_core", {bus.c_gnt, bus.d_gnt}, 2'b10);
        tick();
        bus.c_req = 0; bus.d_req = 0;
        tick();
        chk("abort_next_rdata", bus.c_rdata, 32'hDEADBEEF);
        tick();

        // ---- idle for 20 cycles
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("idle%0d", i),
                {bus.mem_en, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid}, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte address width of all address ports.
REQ-002 Parameter: DATA_W, default 32, data width of all data ports; fixed byte-strobe width DATA_W/8.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 c_req  input  1  core request; c_we input 1 write enable; c_addr input ADDR_W; c_wdata input DATA_W; c_be input DATA_W/8 byte enables.
REQ-007 c_gnt  output  1  core request accepted this cycle; c_rvalid output 1 response valid; c_rdata output DATA_W read data.
REQ-008 d_req, d_we, d_addr, d_wdata, d_be, d_gnt, d_rvalid, d_rdata: debug/loader port, same directions and widths as core port.
REQ-009 mem_en  output  1  memory access strobe; mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_be output DATA_W/8.
REQ-010 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en (synchronous read).

Function
REQ-011 FSM states IDLE, ACCESS, RESP; sequence IDLE->ACCESS->RESP->IDLE; ACCESS and RESP each last exactly one cycle.
REQ-012 In IDLE with one or more req high, the arbiter SHALL assert exactly one gnt (combinational, one-hot) and latch that port's we/addr/wdata/be and winner ID on the same edge, moving to ACCESS.
REQ-013 In IDLE with no req, all gnt low, state remains IDLE.
REQ-014 gnt SHALL be low in ACCESS and RESP regardless of req; requesters hold req and payload stable until gnt.
REQ-015 In ACCESS, mem_en=1 and mem_we/addr/wdata/be driven from latched values; mem_en=0 and mem_we=0 in all other states.
REQ-016 In RESP, winner's rvalid=1 for exactly one cycle and its rdata=mem_rdata; rvalid also pulses for writes (write ack, rdata don't-care).
REQ-017 Non-winning port's rvalid SHALL be 0; rdata outputs return 0 when rvalid is 0.
REQ-018 Latency: gnt in cycle N -> mem_en in N+1 -> rvalid in N+2; next gnt earliest N+2 is not allowed, earliest N+3 (back-to-back throughput one access per 3 cycles).
REQ-019 Round-robin: last_winner register updated on every grant; on simultaneous req, grant the port that is not last_winner.
REQ-020 Single requester SHALL be granted regardless of last_winner.
REQ-021 c_be/d_be of all-zero SHALL still complete the full sequence with mem_be=0.

Reset
REQ-022 Reset SHALL force state IDLE, last_winner=debug (core wins first tie), all latched fields 0.
REQ-023 During and after reset, all gnt, rvalid, mem_en, mem_we 0; mem_addr, mem_wdata, mem_be, rdata 0.
REQ-024 Reset asserted in ACCESS or RESP SHALL abort the transaction: no rvalid is issued for it, next cycle is IDLE.

Configuration
REQ-025 Macro DMEM_ARB_RR_EN: defined -> round-robin per REQ-019; undefined -> fixed priority, core always wins ties, last_winner register removed.

Verification
REQ-026 Core read alone: c_req=1, c_we=0, c_addr=0x10, mem holds 0xDEADBEEF -> c_gnt cycle N, mem_en/addr=0x10 N+1, c_rvalid=1 c_rdata=0xDEADBEEF N+2, d_rvalid=0 throughout.
REQ-027 Debug write: d_we=1, d_addr=0x20, d_wdata=0x12345678, d_be=0xF -> ACCESS cycle shows mem_we=1 addr 0x20 data 0x12345678 be 0xF; d_rvalid pulse next cycle.
REQ-028 Simultaneous req held 4 accesses after reset (RR build) -> grant order core, debug, core, debug, each 3 cycles apart; fixed build -> core, core, core, core.
REQ-029 Request arriving during ACCESS/RESP -> no gnt until IDLE, then granted; payload sampled at gnt only.
REQ-030 rst pulsed during ACCESS of core read -> no c_rvalid, outputs 0, next core req granted as first-after-reset (core wins tie).
REQ-031 Idle bench with no req for 20 cycles -> mem_en, gnt, rvalid all remain 0.
